// File: rtl/sdram_rd_pkg.sv
// Shared types and helpers for the f2h SDRAM burst reader.
// Holds the FSM state encoding, default widths and the 64-bit byte-reversal
// used when SDRAM_RD_BYTESWAP_EN is defined.
package sdram_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_ADDR_W     = 29;
    localparam int DEF_DATA_W     = 64;
    localparam int DEF_BURST_W    = 8;
    localparam int DEF_MAX_BURST  = 32;
    localparam int DEF_FIFO_DEPTH = 128;
    localparam int DEF_LEN_W      = 24;

    // Byte 0 <-> byte 7, byte 1 <-> byte 6, ... for big-endian consumers.
    function automatic logic [63:0] byteswap64(input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*8 +: 8] = d[(7-i)*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sdram_rd_fifo.sv
// First-word-fall-through read-data FIFO with an occupancy count.
// The head word is visible on o_data whenever o_valid is high; storage has
// no reset so it can map onto block RAM.
module sdram_rd_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 128,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Data storage write port.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/f2h_sdram_burst_reader.sv
// Avalon-MM burst read master for one 64-bit HPS FPGA-to-SDRAM port.
// Splits a (word address, word count) command into bursts, buffers the
// returned beats and streams them out with a last-word flag. Reads are only
// issued when the FIFO can absorb every outstanding beat.
// Optional build macro: SDRAM_RD_BYTESWAP_EN (byte-reverse each word on write).
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_ISSUE | issuing bursts until every word has been requested
// ST_DRAIN | all requested, waiting for the last word to leave the FIFO
module f2h_sdram_burst_reader
    import sdram_rd_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BURST_W    = DEF_BURST_W,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [ADDR_W-1:0]  i_cmd_addr,
    input  logic [LEN_W-1:0]   i_cmd_len,
    output logic               o_busy,
    output logic               o_done,
    output logic [ADDR_W-1:0]  o_avm_address,
    output logic [BURST_W-1:0] o_avm_burstcount,
    output logic               o_avm_read,
    input  logic               i_avm_waitrequest,
    input  logic [DATA_W-1:0]  i_avm_readdata,
    input  logic               i_avm_readdatavalid,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [DATA_W-1:0]  o_out_data,
    output logic               o_out_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [BURST_W-1:0] r_burst;
    logic               r_avm_read;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_remaining;
    logic [LEN_W-1:0]   r_pop_cnt;
    logic [CNT_W-1:0]   r_outstanding;

    logic               w_accept;
    logic               w_pop;
    logic               w_last;
    logic               w_fifo_valid;
    logic [CNT_W-1:0]   w_fifo_count;
    logic [DATA_W-1:0]  w_fifo_data;
    logic [DATA_W-1:0]  w_wr_data;
    logic [LEN_W-1:0]   w_first_burst;
    logic [LEN_W-1:0]   w_acc_len;
    logic [LEN_W-1:0]   w_rem_next;
    logic [LEN_W-1:0]   w_burst_next;
    logic [SUM_W-1:0]   w_sum_next;
    logic               w_credit_next;

`ifdef SDRAM_RD_BYTESWAP_EN
    assign w_wr_data = byteswap64(i_avm_readdata);
`else
    assign w_wr_data = i_avm_readdata;
`endif

    sdram_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_avm_readdatavalid),
        .i_data  (w_wr_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign w_accept = r_avm_read && !i_avm_waitrequest;
    assign w_pop    = w_fifo_valid && i_out_ready;
    assign w_last   = w_fifo_valid && (r_pop_cnt == r_len - LEN_W'(1));

    assign o_cmd_ready      = (r_state == ST_IDLE);
    assign o_busy           = (r_state != ST_IDLE);
    assign o_done           = (r_state == ST_DRAIN) && ((r_len == '0) || (w_pop && w_last));
    assign o_avm_address    = r_addr;
    assign o_avm_burstcount = r_burst;
    assign o_avm_read       = r_avm_read;
    assign o_out_valid      = w_fifo_valid;
    assign o_out_data       = w_fifo_valid ? w_fifo_data : '0;
    assign o_out_last       = w_last;

    // Next-cycle burst size and credit: in-flight beats plus FIFO words after
    // this cycle's accept and pop, plus the next burst, must fit the FIFO.
    // A beat landing in the FIFO moves one word between the two terms, so it
    // does not change the sum.
    always_comb begin
        w_first_burst = (i_cmd_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : i_cmd_len;
        w_acc_len     = w_accept ? LEN_W'(r_burst) : '0;
        w_rem_next    = r_remaining - w_acc_len;
        w_burst_next  = (w_rem_next > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : w_rem_next;
        w_sum_next    = SUM_W'(r_outstanding) + SUM_W'(w_fifo_count)
                      + (w_accept ? SUM_W'(r_burst) : '0)
                      - (w_pop ? SUM_W'(1) : '0);
        w_credit_next = (w_sum_next + SUM_W'(w_burst_next)) <= SUM_W'(FIFO_DEPTH);
    end

    // Command FSM, Avalon command register, outstanding and pop counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_burst       <= '0;
            r_avm_read    <= 1'b0;
            r_len         <= '0;
            r_remaining   <= '0;
            r_pop_cnt     <= '0;
            r_outstanding <= '0;
        end else begin
            r_outstanding <= r_outstanding
                           + (w_accept ? CNT_W'(r_burst) : '0)
                           - (i_avm_readdatavalid ? CNT_W'(1) : '0);
            if (w_pop) r_pop_cnt <= r_pop_cnt + LEN_W'(1);

            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        // FIFO is empty and nothing is in flight here, so the
                        // first burst always has credit.
                        r_addr      <= i_cmd_addr;
                        r_len       <= i_cmd_len;
                        r_remaining <= i_cmd_len;
                        r_pop_cnt   <= '0;
                        r_burst     <= BURST_W'(w_first_burst);
                        r_avm_read  <= (i_cmd_len != '0);
                        r_state     <= (i_cmd_len == '0) ? ST_DRAIN : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_accept) begin
                        r_addr      <= r_addr + ADDR_W'(r_burst);
                        r_remaining <= w_rem_next;
                        if (w_rem_next == '0) r_state <= ST_DRAIN;
                    end
                    // Hold the request stable while the slave stalls it.
                    if (!(r_avm_read && i_avm_waitrequest)) begin
                        r_avm_read <= (w_rem_next != '0) && w_credit_next;
                        r_burst    <= BURST_W'(w_burst_next);
                    end
                end
                ST_DRAIN: begin
                    if ((r_len == '0) || (w_pop && w_last)) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_f2h_sdram_burst_reader.sv
// Bench for f2h_sdram_burst_reader: Avalon slave model with fixed read
// latency, stream consumer and a command-level reference model checked
// every cycle, plus literal expectations per scenario.
module tb_f2h_sdram_burst_reader;

    logic        clk;
    logic        i_reset;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [28:0] i_cmd_addr;
    logic [23:0] i_cmd_len;
    logic        o_busy;
    logic        o_done;
    logic [28:0] o_avm_address;
    logic [7:0]  o_avm_burstcount;
    logic        o_avm_read;
    logic        wreq;
    logic [63:0] rd_data;
    logic        rdv;
    logic        o_out_valid;
    logic        out_ready;
    logic [63:0] o_out_data;
    logic        o_out_last;

    f2h_sdram_burst_reader dut (
        .i_clk               (clk),
        .i_reset             (i_reset),
        .i_cmd_valid         (i_cmd_valid),
        .o_cmd_ready         (o_cmd_ready),
        .i_cmd_addr          (i_cmd_addr),
        .i_cmd_len           (i_cmd_len),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_avm_address       (o_avm_address),
        .o_avm_burstcount    (o_avm_burstcount),
        .o_avm_read          (o_avm_read),
        .i_avm_waitrequest   (wreq),
        .i_avm_readdata      (rd_data),
        .i_avm_readdatavalid (rdv),
        .o_out_valid         (o_out_valid),
        .i_out_ready         (out_ready),
        .o_out_data          (o_out_data),
        .o_out_last          (o_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int DEPTH = 128;
    localparam int MAXB  = 32;
    localparam int LAT   = 3;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model of the command in progress
    bit          m_busy;
    logic [28:0] m_addr;
    int          m_len, m_issued, m_popped, m_out, m_vis, m_peak;

    // slave and consumer controls / logs
    typedef struct { int rdy; logic [28:0] a; } beat_t;
    beat_t       beats[$];
    logic [28:0] blog_addr[$];
    int          blog_cnt[$];
    int          blog_cyc[$];
    bit          stall_arm;
    int          stall_left;
    bit          prev_stalled;
    logic [28:0] prev_addr;
    logic [7:0]  prev_cnt;
    bit          ovr;
    bit          rdy_mode;
    int          done_cnt, pop_total, acc_cyc, done_cyc;
    bit          first_cap;
    logic [63:0] first_word;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [28:0] a);
        return {32'(a) ^ 32'hDEAD_BEEF, 32'(a)};
    endfunction

    function automatic logic [63:0] swap_exp(input logic [63:0] d);
`ifdef SDRAM_RD_BYTESWAP_EN
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = d[(7-i)*8 +: 8];
        return r;
`else
        return d;
`endif
    endfunction

    // Per-cycle: drive slave/consumer inputs for the coming edge, compare the
    // DUT against the model, then advance the model across that edge.
    always @(negedge clk) begin : model_proc
        bit exp_valid, pop, acc, last_now, exp_done, cmd_acc;
        int exp_cnt;
        logic [63:0] exp_d;
        cyc++;
        if (i_reset) begin
            wreq = 1'b0; rdv = 1'b0; rd_data = '0; out_ready = 1'b0;
            beats.delete();
            m_busy = 0; m_len = 0; m_issued = 0; m_popped = 0; m_out = 0; m_vis = 0;
            stall_left = 0; stall_arm = 0; prev_stalled = 0;
        end else begin
            out_ready = rdy_mode;
            if (stall_left > 0) begin wreq = 1'b1; stall_left--; end
            else wreq = 1'b0;
            if (beats.size() > 0 && beats[0].rdy <= cyc) begin
                rdv = 1'b1;
                rd_data = ovr ? 64'h0123_4567_89AB_CDEF : mem_word(beats[0].a);
                void'(beats.pop_front());
            end else begin
                rdv = 1'b0;
                rd_data = {$urandom(), $urandom()};
            end

            exp_valid = (m_vis > 0);
            pop       = exp_valid && out_ready;
            last_now  = exp_valid && (m_popped == m_len - 1);
            exp_done  = m_busy && ((m_len == 0) || (pop && last_now));
            cmd_acc   = i_cmd_valid && !m_busy;

            chk("cmd_ready", o_cmd_ready, !m_busy);
            chk("busy", o_busy, m_busy);
            chk("out_valid", o_out_valid, exp_valid);
            chk("done", o_done, exp_done);
            if (exp_valid) begin
                exp_d = ovr ? swap_exp(64'h0123_4567_89AB_CDEF)
                            : swap_exp(mem_word(m_addr + 29'(m_popped)));
                chk("out_data", o_out_data, exp_d);
                chk("out_last", o_out_last, last_now);
            end
            if (!m_busy || m_issued >= m_len) chk("read_when_nothing_left", o_avm_read, 1'b0);
            if (prev_stalled) begin
                chk("stall_read_held", o_avm_read, 1'b1);
                chk("stall_addr_held", o_avm_address, prev_addr);
                chk("stall_cnt_held", o_avm_burstcount, prev_cnt);
            end
            acc = o_avm_read && !wreq;
            prev_stalled = o_avm_read && wreq;
            prev_addr = o_avm_address;
            prev_cnt  = o_avm_burstcount;

            if (acc && m_busy && m_issued < m_len) begin
                exp_cnt = (m_len - m_issued > MAXB) ? MAXB : m_len - m_issued;
                chk("burst_addr", o_avm_address, m_addr + 29'(m_issued));
                chk("burst_cnt", o_avm_burstcount, exp_cnt);
                chk("credit", (m_out + m_vis + int'(o_avm_burstcount)) <= DEPTH, 1'b1);
                blog_addr.push_back(o_avm_address);
                blog_cnt.push_back(int'(o_avm_burstcount));
                blog_cyc.push_back(cyc);
                for (int i = 0; i < int'(o_avm_burstcount); i++)
                    beats.push_back('{cyc + LAT, o_avm_address + 29'(i)});
                m_out    += int'(o_avm_burstcount);
                m_issued += int'(o_avm_burstcount);
                if (stall_arm) begin stall_arm = 0; stall_left = 7; end
            end

            if (pop) begin
                if (!first_cap) begin first_cap = 1; first_word = o_out_data; end
                m_popped++; pop_total++; m_vis--;
            end
            if (rdv) begin
                m_out--; m_vis++;
                chk("fifo_no_overflow", m_vis <= DEPTH, 1'b1);
            end
            if (m_out + m_vis > m_peak) m_peak = m_out + m_vis;
            if (o_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
            if (exp_done) m_busy = 0;
            if (cmd_acc) begin
                m_busy = 1; m_addr = i_cmd_addr; m_len = int'(i_cmd_len);
                m_issued = 0; m_popped = 0; acc_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic start_cmd(input logic [28:0] a, input int len);
        blog_addr.delete(); blog_cnt.delete(); blog_cyc.delete();
        done_cnt = 0; pop_total = 0; first_cap = 0; m_peak = 0;
        i_cmd_addr = a; i_cmd_len = 24'(len); i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (done_cnt == 0 && n < max) begin tick(); n++; end
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL %s: no done after %0d cycles, required done", name, max);
        end
        repeat (3) tick();
    endtask

    initial begin
        int n;
        i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_len = '0;
        wreq = 1'b0; rdv = 1'b0; rd_data = '0; out_ready = 1'b0;
        rdy_mode = 1; ovr = 0; stall_arm = 0;
        repeat (3) tick();
        i_reset = 1'b0;
        @(negedge clk); #1;
        chk("rst cmd_ready", o_cmd_ready, 1'b1);
        chk("rst busy", o_busy, 1'b0);
        chk("rst done", o_done, 1'b0);
        chk("rst avm_read", o_avm_read, 1'b0);
        chk("rst avm_address", o_avm_address, 29'h0);
        chk("rst burstcount", o_avm_burstcount, 8'h0);
        chk("rst out_valid", o_out_valid, 1'b0);
        tick();

        // 1: single short burst
        start_cmd(29'h100, 5);
        wait_done("t1 done", 200);
        chk("t1 bursts", blog_addr.size(), 1);
        chk("t1 addr", blog_addr[0], 29'h100);
        chk("t1 cnt", blog_cnt[0], 5);
        chk("t1 first word", first_word, swap_exp(64'hDEAD_BFEF_0000_0100));
        chk("t1 words", pop_total, 5);
        chk("t1 done once", done_cnt, 1);

        // 2: multi-burst, back-to-back; stray cmd_valid while busy is ignored
        start_cmd(29'h0, 100);
        repeat (4) tick();
        i_cmd_addr = 29'h777; i_cmd_len = 24'd3; i_cmd_valid = 1'b1;
        repeat (3) tick();
        i_cmd_valid = 1'b0;
        wait_done("t2 done", 400);
        chk("t2 bursts", blog_addr.size(), 4);
        for (int i = 0; i < 4 && i < blog_addr.size(); i++) begin
            chk("t2 addr", blog_addr[i], 29'(i * 32));
            chk("t2 cnt", blog_cnt[i], (i == 3) ? 4 : 32);
            if (i > 0) chk("t2 back_to_back", blog_cyc[i] - blog_cyc[i-1], 1);
        end
        chk("t2 words", pop_total, 100);
        chk("t2 done once", done_cnt, 1);

        // 3: 7-cycle waitrequest on the second burst
        stall_arm = 1;
        start_cmd(29'h1000, 64);
        wait_done("t3 done", 400);
        chk("t3 bursts", blog_addr.size(), 2);
        if (blog_addr.size() == 2) begin
            chk("t3 addr2", blog_addr[1], 29'h1020);
            chk("t3 stall gap", blog_cyc[1] - blog_cyc[0], 8);
        end

        // 4: consumer stalled, credit limits reads
        rdy_mode = 0;
        start_cmd(29'h2000, 300);
        repeat (200) tick();
        chk("t4 bursts before drain", blog_addr.size(), 4);
        chk("t4 peak", m_peak, 128);
        chk("t4 read stopped", o_avm_read, 1'b0);
        rdy_mode = 1;
        wait_done("t4 done", 2000);
        chk("t4 bursts", blog_addr.size(), 10);
        chk("t4 words", pop_total, 300);

        // 5: zero length
        start_cmd(29'h55, 0);
        wait_done("t5 done", 20);
        chk("t5 bursts", blog_addr.size(), 0);
        chk("t5 done latency", done_cyc - acc_cyc, 1);
        chk("t5 cmd_ready", o_cmd_ready, 1'b1);

        // 6: reset during drain, then a normal command
        rdy_mode = 0;
        start_cmd(29'h3000, 40);
        n = 0;
        while (!(m_issued == 40 && m_vis >= 8) && n < 300) begin tick(); n++; end
        chk("t6 reached drain", n < 300, 1'b1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        @(negedge clk); #1;
        chk("t6 out_valid", o_out_valid, 1'b0);
        chk("t6 avm_read", o_avm_read, 1'b0);
        chk("t6 cmd_ready", o_cmd_ready, 1'b1);
        tick();
        rdy_mode = 1;
        start_cmd(29'h3100, 9);
        wait_done("t6 done", 200);
        chk("t6 words", pop_total, 9);
        chk("t6 done once", done_cnt, 1);

        // address wrap at the top of the word space
        start_cmd(29'h1FFF_FFFE, 4);
        wait_done("wrap done", 200);
        chk("wrap addr", blog_addr.size() > 0 ? blog_addr[0] : 29'h0, 29'h1FFF_FFFE);
        chk("wrap words", pop_total, 4);

        // fixed data word through the byte lane path
        ovr = 1;
        start_cmd(29'h10, 1);
        wait_done("swap done", 200);
`ifdef SDRAM_RD_BYTESWAP_EN
        chk("swap word", first_word, 64'hEFCD_AB89_6745_2301);
`else
        chk("swap word", first_word, 64'h0123_4567_89AB_CDEF);
`endif
        ovr = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

endmodule
